// File: rtl/connect4_pkg.sv
// Shared Connect-4 constants: board size, turn-sequencer states and winner codes.
package connect4_pkg;
  localparam int COLS = 7;
  localparam int ROWS = 6;

  typedef enum logic [1:0] {
    SELECT = 2'd0,
    WRITE  = 2'd1,
    CHECK  = 2'd2,
    OVER   = 2'd3
  } state_t;

  localparam logic [1:0] WIN_NONE = 2'b00;
  localparam logic [1:0] WIN_P1   = 2'b01;
  localparam logic [1:0] WIN_P2   = 2'b10;
  localparam logic [1:0] WIN_DRAW = 2'b11;
endpackage

// File: rtl/column_heights.sv
// Per-column fill counters with one indexed read/increment port.
// Out-of-range indices read as full so callers can treat them as unplayable.
module column_heights #(
  parameter int COLS = 7,
  parameter int ROWS = 6,
  parameter int CW   = 3,
  parameter int RW   = 3
) (
  input  logic          clock,
  input  logic          rst,
  input  logic [CW-1:0] i_idx,
  input  logic          i_inc,
  output logic [RW-1:0] o_fill,
  output logic          o_full
);
  logic [RW-1:0] r_fill [COLS];
  logic          w_in_range;

  assign w_in_range = (i_idx < CW'(COLS));

  always_comb begin
    o_fill = '0;
    o_full = 1'b1;
    if (w_in_range) begin
      o_fill = r_fill[i_idx];
      o_full = (r_fill[i_idx] >= RW'(ROWS));
    end
  end

  always_ff @(posedge clock) begin
    if (rst) begin
      for (int i = 0; i < COLS; i++) r_fill[i] <= '0;
    end else if (i_inc && !o_full) begin
      r_fill[i_idx] <= r_fill[i_idx] + 1'b1;
    end
  end
endmodule

// File: rtl/turn_controller.sv
// Connect-4 turn sequencer: drop capture, board write, win-check handshake, player hand-over.
//   state  | meaning
//   SELECT | cursor free, waiting for a drop edge
//   WRITE  | one-cycle board write of the captured cell
//   CHECK  | waiting for the win checker verdict
//   OVER   | game finished, inputs ignored until rst
module turn_controller #(
  parameter int COLS = connect4_pkg::COLS,
  parameter int ROWS = connect4_pkg::ROWS,
  parameter int CW   = 3,
  parameter int RW   = 3
) (
  input  logic          clock,
  input  logic          rst,
  input  logic [CW-1:0] col_pos,
  input  logic          drop_btn,
  output logic          move_en,
  output logic          wr_en,
  output logic [CW-1:0] wr_col,
  output logic [RW-1:0] wr_row,
  output logic          wr_player,
  output logic          chk_start,
  input  logic          chk_done,
  input  logic          chk_win,
  output logic          cur_player,
  output logic          reject,
  output logic          game_over,
  output logic [1:0]    winner
);
  import connect4_pkg::*;

  localparam logic [5:0] MOVES_MAX = 6'(COLS * ROWS);

  state_t        r_state, w_state_next;
  logic          r_drop_prev, w_drop_edge;
  logic [CW-1:0] r_wr_col, w_idx;
  logic [RW-1:0] r_wr_row, w_fill;
  logic          r_wr_player, r_chk_start, r_reject, r_cur_player, r_game_over;
  logic [1:0]    r_winner;
  logic [5:0]    r_moves;
  logic          w_full, w_accept;

  assign w_drop_edge = drop_btn & ~r_drop_prev;
  // The counter port reads the cursor column while selecting and the captured column while writing.
  assign w_idx       = (r_state == WRITE) ? r_wr_col : col_pos;
  assign w_accept    = (r_state == SELECT) && w_drop_edge && !w_full;

  column_heights #(.COLS(COLS), .ROWS(ROWS), .CW(CW), .RW(RW)) u_heights (
    .clock  (clock),
    .rst    (rst),
    .i_idx  (w_idx),
    .i_inc  (r_state == WRITE),
    .o_fill (w_fill),
    .o_full (w_full)
  );

  always_comb begin
    w_state_next = r_state;
    case (r_state)
      SELECT: if (w_accept) w_state_next = WRITE;
      WRITE:  w_state_next = CHECK;
      CHECK:  if (chk_done) w_state_next = (chk_win || r_moves == MOVES_MAX) ? OVER : SELECT;
      OVER:   w_state_next = OVER;
      default: w_state_next = SELECT;
    endcase
  end

  always_ff @(posedge clock) begin
    if (rst) begin
      r_state      <= SELECT;
      r_drop_prev  <= 1'b0;
      r_wr_col     <= '0;
      r_wr_row     <= '0;
      r_wr_player  <= 1'b0;
      r_chk_start  <= 1'b0;
      r_reject     <= 1'b0;
      r_cur_player <= 1'b0;
      r_game_over  <= 1'b0;
      r_winner     <= WIN_NONE;
      r_moves      <= '0;
    end else begin
      r_state     <= w_state_next;
      r_drop_prev <= drop_btn;
      r_chk_start <= (r_state == WRITE);
      r_reject    <= (r_state == SELECT) && w_drop_edge && w_full;
      if (w_accept) begin
        r_wr_col    <= col_pos;
        r_wr_row    <= w_fill;
        r_wr_player <= r_cur_player;
      end
      if (r_state == WRITE) r_moves <= r_moves + 6'd1;
      if (r_state == CHECK && chk_done) begin
        // A win on the final move takes precedence over a draw.
        if (chk_win) begin
          r_game_over <= 1'b1;
          r_winner    <= r_cur_player ? WIN_P2 : WIN_P1;
        end else if (r_moves == MOVES_MAX) begin
          r_game_over <= 1'b1;
          r_winner    <= WIN_DRAW;
        end else begin
          r_cur_player <= ~r_cur_player;
        end
      end
    end
  end

  assign move_en    = (r_state == SELECT);
  assign wr_en      = (r_state == WRITE);
  assign wr_col     = r_wr_col;
  assign wr_row     = r_wr_row;
  assign wr_player  = r_wr_player;
  assign chk_start  = r_chk_start;
  assign cur_player = r_cur_player;
  assign reject     = r_reject;
  assign game_over  = r_game_over;
  assign winner     = r_winner;
endmodule

// File: doc/turn_controller.md
Name: turn_controller

Overview:
- Game sequencer for Connect-4. Sits between the column-position mover, the drop button, the board memory write port and the win checker.
- Captures the selected column on a drop press, computes the landing row from per-column fill counters, and issues one board write.
- Runs a win-check handshake, then alternates players or ends the game.
- Gates the left/right movement buttons so the cursor cannot move mid-turn.

Parameters:
- COLS, 7, number of board columns.
- ROWS, 6, number of board rows; the fill counter saturates at ROWS.
- CW, 3, width of column indices.
- RW, 3, width of row indices and fill counters.

Ports:
- clock  in  1  system clock
- rst  in  1  reset, synchronous, active-high
- col_pos  in  CW  current cursor column from the position mover
- drop_btn  in  1  drop button level, already debounced and synchronised
- move_en  out  1  high when the position mover buttons may be honoured
- wr_en  out  1  one-cycle board write strobe
- wr_col  out  CW  board write column
- wr_row  out  RW  board write row; 0 is the bottom row
- wr_player  out  1  piece colour to write (0 = P1, 1 = P2)
- chk_start  out  1  one-cycle pulse to the win checker
- chk_done  in  1  win checker finished; valid for one cycle
- chk_win  in  1  sampled with chk_done; the last move produced four-in-a-row
- cur_player  out  1  player whose turn it is
- reject  out  1  one-cycle pulse when a drop targets a full or invalid column
- game_over  out  1  latched end-of-game flag
- winner  out  2  00 none, 01 P1, 10 P2, 11 draw

Behaviour:
Reset (rst high at a clock edge):
- state = SELECT, cur_player = 0, all fill counters = 0, move counter = 0, drop_prev = 0.
- wr_en = chk_start = reject = 0, game_over = 0, winner = 00.
- rst overrides every state, including mid-check; a chk_done arriving after reset is ignored.

Drop detection:
- drop_edge = drop_btn & ~drop_prev; drop_prev is updated every cycle in every state.
- Edges outside SELECT are discarded, never queued.

FSM states:
- SELECT:
  - move_en = 1.
  - On drop_edge with col_pos < COLS and fill[col_pos] < ROWS: latch col_pos and fill[col_pos] into wr_col and wr_row; go to WRITE.
  - On drop_edge with col_pos >= COLS or the column full: pulse reject in the next cycle and stay in SELECT; no counter changes.
- WRITE:
  - Exactly one cycle. wr_en = 1, wr_player = cur_player.
  - fill[wr_col] increments and the move counter increments at the end of this cycle.
  - Next state is CHECK with chk_start = 1 in its first cycle only.
- CHECK:
  - Wait for chk_done. No timeout.
  - If chk_done and chk_win: game_over = 1, winner = cur_player ? 10 : 01; go to OVER.
  - Else if chk_done and move counter == COLS*ROWS (42): game_over = 1, winner = 11; go to OVER.
  - Else if chk_done: toggle cur_player; go to SELECT.
  - A win on the 42nd move is reported as a win, not a draw.
  - chk_done in the same cycle as chk_start is legal and is handled.
- OVER:
  - move_en = 0; all inputs are ignored until rst.

Output timing:
- move_en = 0 in WRITE, CHECK and OVER.
- Latency from drop_edge to wr_en is 1 cycle.
- wr_col, wr_row and wr_player hold their values from WRITE until the next WRITE.

Width rules:
- Fill counters are RW bits and never exceed ROWS.
- The move counter is 6 bits and never exceeds 42.

Decomposition:
- Package connect4_pkg holds:
  - COLS and ROWS constants.
  - state_t enum {SELECT, WRITE, CHECK, OVER}.
  - winner encoding constants WIN_NONE, WIN_P1, WIN_P2, WIN_DRAW.
- Sub-module column_heights: array of COLS fill counters with a read-by-index port, increment enable and full flag. Reused later by the VGA piece renderer.
- Drop edge detection stays inline.

Test Plan:
- Reset, col_pos = 3, drop pulse -> next cycle wr_en = 1, wr_col = 3, wr_row = 0, wr_player = 0; then chk_start pulse. chk_done = 1, chk_win = 0 -> cur_player = 1, move_en = 1.
- Six alternating drops into column 2 (no wins), then a 7th drop -> wr_row goes 0..5; 7th gives reject = 1, no wr_en, cur_player unchanged.
- col_pos = 7, drop -> reject = 1, no write, state stays SELECT.
- P1 move followed by chk_done = 1, chk_win = 1 -> game_over = 1, winner = 01, move_en = 0. Further drops produce no wr_en.
- Fill all 42 cells with chk_win = 0 -> after the 42nd chk_done, winner = 11, game_over = 1. Repeat with chk_win = 1 on the 42nd move -> winner = 10.
- Drop held high across WRITE and CHECK, plus a second edge during CHECK -> only one write occurs. Assert rst during CHECK -> all fill counters = 0, winner = 00, and a late chk_done is ignored.
